// File: rtl/quad_ab_tx.sv
// Quadrature A/B pulse transmitter: emits N Gray-coded A/B steps at a
// programmable period while tracking a signed position count.
module quad_ab_tx #(
    parameter int CNT_W = 32,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_a;
    logic             r_b;
    logic             r_dir;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_nx;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_pos;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_due;
    logic             w_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_due      = 1'b0;
        w_step     = 1'b0;
        w_phase_nx = r_phase;
        unique case (r_state)
            S_IDLE: begin
                w_accept = r_ready & cmd_valid;
                if (w_accept) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                w_due  = (r_rem != '0) && (r_cnt == r_div);
                // abort wins over a step that falls due in the same cycle
                w_step = w_due & ~abort;
                if (abort || (r_rem == '0)) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        if (w_step) begin
            w_phase_nx = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_phase <= 2'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
        end else begin
            r_ready <= (w_state_nx == S_IDLE);
            r_busy  <= (w_state_nx == S_RUN);
            r_done  <= (w_state_nx == S_DONE);
            r_phase <= w_phase_nx;
            // phase index 0..3 maps to {a,b} = 00,10,11,01
            r_a     <= w_phase_nx[1] ^ w_phase_nx[0];
            r_b     <= w_phase_nx[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_dir <= 1'b0;
            r_div <= '0;
            r_cnt <= '0;
            r_pos <= '0;
        end else if (w_accept) begin
            r_rem <= cmd_steps;
            r_dir <= cmd_dir;
            r_div <= cmd_div;
            r_cnt <= '0;
        end else if ((r_state == S_RUN) && !abort) begin
            if (w_due) begin
                r_cnt <= '0;
                r_rem <= r_rem - CNT_ONE;
                r_pos <= r_dir ? (r_pos - CNT_ONE) : (r_pos + CNT_ONE);
            end else if (r_rem != '0) begin
                r_cnt <= r_cnt + DIV_ONE;
            end
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign a         = r_a;
    assign b         = r_b;
    assign pos       = r_pos;

endmodule
